// File: rtl/tns_frame_scheduler.sv
// tns_frame_scheduler: gathers input beats into a frame, launches it into the TNS encoder array, and returns the codewords.
// Optional partial-frame flush port is enabled by defining TNS_SCHED_FLUSH_EN.
module tns_frame_scheduler #(
  parameter int GROUPS      = 20,
  parameter int GDATA_W     = 11,
  parameter int GCODE_W     = 12,
  parameter int BEAT_GROUPS = 2,
  parameter int ENC_LAT     = 1,
  localparam int DIN_W = BEAT_GROUPS*GDATA_W,
  localparam int BEATS = GROUPS/BEAT_GROUPS,
  localparam int FD_W  = GROUPS*GDATA_W,
  localparam int FC_W  = GROUPS*GCODE_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DIN_W-1:0]  i_in_data,
  output logic [FD_W-1:0]   o_enc_datain,
  input  logic [FC_W-1:0]   i_enc_codeout,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [FC_W-1:0]   o_out_code,
  output logic              o_busy
`ifdef TNS_SCHED_FLUSH_EN
  ,
  input  logic              i_flush
`endif
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW = $clog2(ENC_LAT+1);

  if (GROUPS % BEAT_GROUPS != 0) begin : g_bad_cfg
    $error("GROUPS must be a multiple of BEAT_GROUPS");
  end

  typedef enum logic [1:0] {S_FILL = 2'd0, S_WAIT = 2'd1, S_OUT = 2'd2} state_t;

  state_t            r_state, w_state;
  logic [BW-1:0]     r_beat_cnt, w_beat_cnt;
  logic [LW-1:0]     r_lat_cnt, w_lat_cnt;
  logic [FD_W-1:0]   r_fill, w_fill, w_fill_wr;
  logic [FD_W-1:0]   r_enc, w_enc;
  logic [FC_W-1:0]   r_code, w_code;
  logic              r_in_ready, r_out_valid;
  logic              w_acc, w_last, w_flush;

  always_comb begin
    w_acc  = (r_state == S_FILL) && i_in_valid && r_in_ready;
    w_last = w_acc && (r_beat_cnt == BW'(BEATS-1));
`ifdef TNS_SCHED_FLUSH_EN
    w_flush = (r_state == S_FILL) && i_flush && ((r_beat_cnt != '0) || w_acc);
`else
    w_flush = 1'b0;
`endif
    // The buffer is cleared at every launch, so unwritten groups are already zero padding.
    w_fill_wr = r_fill;
    if (w_acc) w_fill_wr[r_beat_cnt*DIN_W +: DIN_W] = i_in_data;
  end

  always_comb begin
    w_state    = r_state;
    w_beat_cnt = r_beat_cnt;
    w_lat_cnt  = r_lat_cnt;
    w_fill     = r_fill;
    w_enc      = r_enc;
    w_code     = r_code;
    case (r_state)
      S_FILL: begin
        if (w_last || w_flush) begin
          w_state    = S_WAIT;
          w_beat_cnt = '0;
          w_lat_cnt  = '0;
          w_fill     = '0;
          w_enc      = w_fill_wr;
        end else if (w_acc) begin
          w_beat_cnt = r_beat_cnt + 1'b1;
          w_fill     = w_fill_wr;
        end
      end
      S_WAIT: begin
        w_lat_cnt = r_lat_cnt + 1'b1;
        if (r_lat_cnt == LW'(ENC_LAT)) begin
          w_state = S_OUT;
          w_code  = i_enc_codeout;
        end
      end
      S_OUT: w_state = i_out_ready ? S_FILL : S_OUT;
      default: begin
        w_state    = S_FILL;
        w_beat_cnt = '0;
        w_lat_cnt  = '0;
        w_fill     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_FILL;
      r_beat_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_fill      <= '0;
      r_enc       <= '0;
      r_code      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_beat_cnt  <= w_beat_cnt;
      r_lat_cnt   <= w_lat_cnt;
      r_fill      <= w_fill;
      r_enc       <= w_enc;
      r_code      <= w_code;
      r_in_ready  <= (w_state == S_FILL);
      r_out_valid <= (w_state == S_OUT);
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_enc_datain = r_enc;
  assign o_out_code   = r_code;
  assign o_busy       = !((r_state == S_FILL) && (r_beat_cnt == '0));
endmodule

// File: tb/tb_tns_frame_scheduler.sv
// tb_tns_frame_scheduler: directed and randomized frames checked against a frame-level reference model.
module tb_tns_frame_scheduler;
  localparam int GROUPS = 20, GDATA_W = 11, GCODE_W = 12, BEAT_GROUPS = 2, ENC_LAT = 1;
  localparam int DIN_W = BEAT_GROUPS*GDATA_W, BEATS = GROUPS/BEAT_GROUPS;
  localparam int FD_W = GROUPS*GDATA_W, FC_W = GROUPS*GCODE_W;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [DIN_W-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [FD_W-1:0] enc_datain;
  logic [FC_W-1:0] enc_codeout, out_code;
  logic [FC_W-1:0] enc_pipe [ENC_LAT];
  logic [DIN_W-1:0] beats[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  tns_frame_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_enc_datain(enc_datain), .i_enc_codeout(enc_codeout),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_code(out_code), .o_busy(busy)
`ifdef TNS_SCHED_FLUSH_EN
    , .i_flush(flush)
`endif
  );

  function automatic logic [GCODE_W-1:0] enc12(input logic [GDATA_W-1:0] d);
    return {^d, d[0] ^ d[10], d[9:0] ^ {d[4:0], d[9:5]}};
  endfunction

  function automatic logic [FC_W-1:0] model_code(input logic [FD_W-1:0] f);
    logic [FC_W-1:0] c = '0;
    for (int g = 0; g < GROUPS; g++) c[g*GCODE_W +: GCODE_W] = enc12(f[g*GDATA_W +: GDATA_W]);
    return c;
  endfunction

  function automatic logic [FD_W-1:0] frame_of();
    logic [FD_W-1:0] f = '0;
    foreach (beats[k]) f[k*DIN_W +: DIN_W] = beats[k];
    return f;
  endfunction

  always @(posedge clk) begin
    enc_pipe[0] <= model_code(enc_datain);
    for (int i = 1; i < ENC_LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
  end
  assign enc_codeout = enc_pipe[ENC_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [FC_W-1:0] obs, input logic [FC_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_enc_datain"}, enc_datain, 0);
    chk({tag, "_out_code"}, out_code, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 0;
    #1;
    rst_chk(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
    chk({tag, "_ready_after"}, in_ready, 1);
  endtask

  task automatic send(input logic [DIN_W-1:0] d);
    int n = 0;
    logic acc;
    in_valid = 1;
    in_data = d;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    in_valid = 0;
    chk("beat_accepted", acc, 1);
  endtask

  task automatic post_launch(input logic [FD_W-1:0] fr, input int hold, input bit ign);
    chk("launch_data", enc_datain, fr);
    chk("launch_ready_low", in_ready, 0);
    chk("launch_busy", busy, 1);
    chk("launch_valid_low", out_valid, 0);
    if (ign) begin
      in_valid = 1;
      in_data = 22'h3FFFFF;
    end
    out_ready = (hold == 0);
    step();
    chk("wait_valid_low", out_valid, 0);
    chk("wait_ready_low", in_ready, 0);
    step();
    chk("out_valid", out_valid, 1);
    chk("out_code", out_code, model_code(fr));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_code", out_code, model_code(fr));
      chk("hold_ready_low", in_ready, 0);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_ready_high", in_ready, 1);
    chk("hs_busy_low", busy, 0);
    chk("hs_enc_held", enc_datain, fr);
  endtask

  task automatic run_frame(input bit toggle, input int hold, input bit ign);
    foreach (beats[k]) begin
      if (toggle && k > 0) begin
        in_valid = 0;
        step();
        chk("stall_busy", busy, 1);
      end
      send(beats[k]);
    end
    post_launch(frame_of(), hold, ign);
  endtask

  task automatic rand_beats(input int n);
    beats.delete();
    for (int k = 0; k < n; k++) beats.push_back(DIN_W'($urandom));
  endtask

  initial begin
    #2;
    rst_chk("reset");
    @(negedge clk);
    rst_n = 1;
    step();
    chk("ready_after_reset", in_ready, 1);
    chk("idle_busy", busy, 0);

    beats.delete();
    for (int k = 0; k < BEATS; k++) beats.push_back(DIN_W'(k + 1));
    run_frame(0, 0, 0);

    rand_beats(BEATS);
    run_frame(0, 5, 0);

    beats.delete();
    for (int k = 0; k < BEATS; k++) beats.push_back(DIN_W'(k + 1));
    run_frame(1, $urandom_range(1, 4), 0);

    for (int k = 0; k < 4; k++) send(DIN_W'($urandom));
    pulse_reset("rst_fill");
    rand_beats(BEATS);
    foreach (beats[k]) send(beats[k]);
    chk("pre_rst_launch", enc_datain, frame_of());
    pulse_reset("rst_wait");
    rand_beats(BEATS);
    run_frame(0, 2, 0);

    rand_beats(BEATS);
    run_frame(0, 3, 1);
    rand_beats(BEATS);
    beats[0] = 22'h3FFFFF;
    run_frame(0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      rand_beats(BEATS);
      run_frame($urandom_range(0, 1), $urandom_range(0, 3), 0);
    end

`ifdef TNS_SCHED_FLUSH_EN
    flush = 1;
    step();
    flush = 0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_ready", in_ready, 1);
    beats.delete();
    for (int k = 0; k < 3; k++) begin
      beats.push_back(DIN_W'(k + 1));
      send(beats[k]);
    end
    flush = 1;
    step();
    flush = 0;
    post_launch(frame_of(), 0, 0);
    rand_beats(3);
    send(beats[0]);
    send(beats[1]);
    flush = 1;
    send(beats[2]);
    flush = 0;
    post_launch(frame_of(), 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
